// File: rtl/sec_ded_pkg.sv
// rtl/sec_ded_pkg.sv - Hsiao (39,32) SEC-DED code constants shared by encoder, decoder and scrubber
package sec_ded_pkg;
   localparam int DATA_W = 32;
   localparam int CHK_W  = 7;
   localparam int CW_W   = 39;

   // MASKS[i] selects the data bits covered by check bit i
   localparam logic [CHK_W-1:0][DATA_W-1:0] MASKS = {
      32'h5403FF10, 32'h8B503E88, 32'hA2BBC244, 32'h7D9C4422,
      32'hC06C89E1, 32'h13E5101F, 32'h2C0221FF
   };

   function automatic logic [CHK_W-1:0] data_col(input logic [4:0] idx);
      logic [CHK_W-1:0] col;
      for (int i = 0; i < CHK_W; i++) col[i] = MASKS[i][idx];
      return col;
   endfunction

   function automatic logic [CHK_W-1:0] chk_bits(input logic [DATA_W-1:0] data);
      logic [CHK_W-1:0] chk;
      for (int i = 0; i < CHK_W; i++) chk[i] = ^(data & MASKS[i]);
      return chk;
   endfunction
endpackage

// File: rtl/sec_ded_syn.sv
// rtl/sec_ded_syn.sv - combinational syndrome, correction mask and CE/UE classification
module sec_ded_syn
   import sec_ded_pkg::*;
(
   input  logic [CW_W-1:0]   cw_i,
   output logic [CHK_W-1:0]  syn_o,
   output logic [DATA_W-1:0] flip_o,
   output logic              ce_o,
   output logic              ue_o
);
   logic chk_hit;

   always_comb begin
      syn_o = chk_bits(cw_i[DATA_W-1:0]) ^ cw_i[CW_W-1:DATA_W];
      for (int j = 0; j < DATA_W; j++) flip_o[j] = (syn_o == data_col(5'(j)));
      // a one-hot syndrome points at a flipped check bit; data is already right
      chk_hit = (syn_o != '0) && ((syn_o & (syn_o - CHK_W'(1))) == '0);
      ce_o    = (|flip_o) || chk_hit;
      ue_o    = (syn_o != '0) && !ce_o;
   end
endmodule

// File: rtl/sec_ded_dec_top.sv
// rtl/sec_ded_dec_top.sv - two-stage SEC-DED decoder with valid/ready handshake and CE/UE counters
module sec_ded_dec_top
   import sec_ded_pkg::*;
#(
   parameter int CNT_W = 16
)
(
   input  logic             CLK,
   input  logic             RST,
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic [38:0]      IN,
   output logic             OUT_VALID,
   input  logic             OUT_READY,
   output logic [31:0]      OUT,
   output logic [6:0]       SYN,
   output logic             CE,
   output logic             UE,
   input  logic             CLR_CNT,
   output logic [CNT_W-1:0] CE_CNT,
   output logic [CNT_W-1:0] UE_CNT
);
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CHK_W-1:0]  in_syn;
   logic [DATA_W-1:0] in_flip;
   logic              in_ce, in_ue;

   logic              s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
   logic              s1_load, s2_load;
   logic [DATA_W-1:0] s1_data_q, s1_flip_q;
   logic [CHK_W-1:0]  s1_syn_q;
   logic              s1_ce_q, s1_ue_q;
   logic [CNT_W-1:0]  ce_cnt_q, ce_cnt_d, ue_cnt_q, ue_cnt_d;

   sec_ded_syn u_syn (
      .cw_i   (IN),
      .syn_o  (in_syn),
      .flip_o (in_flip),
      .ce_o   (in_ce),
      .ue_o   (in_ue)
   );

   always_comb begin
      s2_load    = !s2_valid_q || OUT_READY;
      s1_load    = !s1_valid_q || s2_load;
      s1_valid_d = s1_load ? IN_VALID : s1_valid_q;
      s2_valid_d = s2_load ? s1_valid_q : s2_valid_q;

      // clear takes priority and swallows any increment landing in the same cycle
      ce_cnt_d = ce_cnt_q;
      ue_cnt_d = ue_cnt_q;
      if (CLR_CNT) begin
         ce_cnt_d = '0;
         ue_cnt_d = '0;
      end else if (s2_load && s1_valid_q) begin
         if (s1_ce_q && !(&ce_cnt_q)) ce_cnt_d = ce_cnt_q + CNT_ONE;
         if (s1_ue_q && !(&ue_cnt_q)) ue_cnt_d = ue_cnt_q + CNT_ONE;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         s1_data_q  <= '0;
         s1_flip_q  <= '0;
         s1_syn_q   <= '0;
         s1_ce_q    <= 1'b0;
         s1_ue_q    <= 1'b0;
         OUT        <= '0;
         SYN        <= '0;
         CE         <= 1'b0;
         UE         <= 1'b0;
         ce_cnt_q   <= '0;
         ue_cnt_q   <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s2_valid_q <= s2_valid_d;
         ce_cnt_q   <= ce_cnt_d;
         ue_cnt_q   <= ue_cnt_d;
         if (s1_load && IN_VALID) begin
            s1_data_q <= IN[DATA_W-1:0];
            s1_flip_q <= in_flip;
            s1_syn_q  <= in_syn;
            s1_ce_q   <= in_ce;
            s1_ue_q   <= in_ue;
         end
         if (s2_load && s1_valid_q) begin
            OUT <= s1_data_q ^ s1_flip_q;
            SYN <= s1_syn_q;
            CE  <= s1_ce_q;
            UE  <= s1_ue_q;
         end
      end
   end

   assign IN_READY  = s1_load;
   assign OUT_VALID = s2_valid_q;
   assign CE_CNT    = ce_cnt_q;
   assign UE_CNT    = ue_cnt_q;
endmodule

// File: tb/tb_sec_ded_dec_top.sv
// tb/tb_sec_ded_dec_top.sv - scoreboard bench for the SEC-DED decoder
module tb_sec_ded_dec_top;
   localparam int CNT_W = 2;
   localparam int MAXC  = (1 << CNT_W) - 1;
   localparam logic [6:0][31:0] TB_M = {
      32'h5403FF10, 32'h8B503E88, 32'hA2BBC244, 32'h7D9C4422,
      32'hC06C89E1, 32'h13E5101F, 32'h2C0221FF
   };

   typedef struct {
      logic [31:0] out;
      logic [6:0]  syn;
      logic        ce;
      logic        ue;
      int          t;
   } exp_t;

   logic             clk, rst, in_valid, in_ready, out_valid, out_ready, clr_cnt;
   logic [38:0]      in_cw;
   logic [31:0]      out_data;
   logic [6:0]       syn;
   logic             ce, ue;
   logic [CNT_W-1:0] ce_cnt, ue_cnt;

   exp_t sbq[$];
   int   n_vec = 0, n_err = 0, cyc = 0, m_ce = 0, m_ue = 0;
   logic lat_chk = 0, stalled_prev = 0, last_taken = 0, last_in_ready = 0, ovr_valid = 0;
   exp_t ovr_e;

   sec_ded_dec_top #(.CNT_W(CNT_W)) dut (
      .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready), .IN(in_cw),
      .OUT_VALID(out_valid), .OUT_READY(out_ready), .OUT(out_data), .SYN(syn),
      .CE(ce), .UE(ue), .CLR_CNT(clr_cnt), .CE_CNT(ce_cnt), .UE_CNT(ue_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [6:0] tb_enc(input logic [31:0] d);
      logic [6:0] c;
      for (int i = 0; i < 7; i++) c[i] = ^(d & TB_M[i]);
      return c;
   endfunction

   function automatic exp_t tb_model(input logic [38:0] cw);
      exp_t e;
      logic [6:0] s, col;
      s = tb_enc(cw[31:0]) ^ cw[38:32];
      e.out = cw[31:0]; e.syn = s; e.ce = 1'b0; e.ue = 1'b0; e.t = 0;
      if (s != 7'd0) begin
         if ($countones(s) == 1) e.ce = 1'b1;
         for (int j = 0; j < 32; j++) begin
            for (int k = 0; k < 7; k++) col[k] = TB_M[k][j];
            if (col == s) begin
               e.out[j] = ~e.out[j];
               e.ce = 1'b1;
            end
         end
         e.ue = !e.ce;
      end
      return e;
   endfunction

   task automatic cyc_step(input logic vld, input logic [38:0] cw, input logic ordy, input logic clr);
      exp_t e;
      @(negedge clk);
      in_valid = vld; in_cw = cw; out_ready = ordy; clr_cnt = clr;
      #1;
      last_in_ready = in_ready;
      last_taken = vld && in_ready;
      if (stalled_prev) check_eq("hold_valid", out_valid, 1);
      if (sbq.size() == 0) begin
         check_eq("idle_valid", out_valid, 0);
      end else if (out_valid) begin
         e = sbq[0];
         check_eq("out", out_data, e.out);
         check_eq("syn", syn, e.syn);
         check_eq("ce", ce, e.ce);
         check_eq("ue", ue, e.ue);
         if (out_ready) begin
            void'(sbq.pop_front());
            if (lat_chk) check_eq("latency", cyc - e.t, 2);
         end
      end
      stalled_prev = out_valid && !out_ready;
      if (clr) begin
         m_ce = 0;
         m_ue = 0;
      end
      if (last_taken) begin
         e = ovr_valid ? ovr_e : tb_model(cw);
         e.t = cyc;
         sbq.push_back(e);
         if (e.ce && m_ce < MAXC) m_ce++;
         if (e.ue && m_ue < MAXC) m_ue++;
      end
      cyc++;
   endtask

   task automatic send_exp(input logic [38:0] cw, input logic [31:0] o, input logic [6:0] s,
                           input logic c, input logic u);
      ovr_e = '{o, s, c, u, 0};
      ovr_valid = 1'b1;
      cyc_step(1'b1, cw, 1'b1, 1'b0);
      ovr_valid = 1'b0;
      check_eq("dir_taken", last_taken, 1);
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && sbq.size() > 0; i++) cyc_step(1'b0, '0, 1'b1, 1'b0);
      check_eq("drained", sbq.size(), 0);
      check_eq("ce_cnt", ce_cnt, m_ce);
      check_eq("ue_cnt", ue_cnt, m_ue);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b0; in_cw = '0; out_ready = 1'b1; clr_cnt = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      sbq.delete();
      stalled_prev = 1'b0;
      m_ce = 0;
      m_ue = 0;
      check_eq("rst_out_valid", out_valid, 0);
      check_eq("rst_out", out_data, 0);
      check_eq("rst_syn", syn, 0);
      check_eq("rst_ce", ce, 0);
      check_eq("rst_ue", ue, 0);
      check_eq("rst_ce_cnt", ce_cnt, 0);
      check_eq("rst_ue_cnt", ue_cnt, 0);
      check_eq("rst_in_ready", in_ready, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [38:0] cw, bpw[5], rw[64];
      logic [31:0] d;
      exp_t e;
      int idx, p1, p2;

      rst = 1'b1; in_valid = 1'b0; in_cw = '0; out_ready = 1'b1; clr_cnt = 1'b0;
      do_reset();

      lat_chk = 1'b1;
      send_exp(39'h00_0000_0000, 32'h0000_0000, 7'h00, 1'b0, 1'b0);
      send_exp(39'h24_FFFF_FFFF, 32'hFFFF_FFFF, 7'h00, 1'b0, 1'b0);
      drain();

      send_exp(39'h00_0000_0001, 32'h0000_0000, 7'h07, 1'b1, 1'b0);
      drain();
      check_eq("ce_cnt_one", ce_cnt, 1);

      for (int j = 0; j < 32; j++) begin
         cw = {7'h24, 32'hFFFF_FFFF} ^ (39'd1 << j);
         e = tb_model(cw);
         send_exp(cw, 32'hFFFF_FFFF, e.syn, 1'b1, 1'b0);
      end
      drain();

      for (int i = 0; i < 7; i++) send_exp(39'd1 << (32 + i), 32'h0, 7'd1 << i, 1'b1, 1'b0);
      drain();

      cyc_step(1'b0, '0, 1'b1, 1'b1);
      send_exp(39'h00_0000_0003, 32'h0000_0003, 7'h0C, 1'b0, 1'b1);
      drain();
      check_eq("ue_cnt_one", ue_cnt, 1);
      lat_chk = 1'b0;

      for (int k = 0; k < 5; k++) begin
         d = {8{4'(k + 1)}};
         bpw[k] = {tb_enc(d), d};
      end
      idx = 0;
      for (int c = 0; c < 14; c++) begin
         cyc_step(idx < 5, bpw[idx < 5 ? idx : 0], c >= 4, 1'b0);
         if (c < 4) check_eq("bp_in_ready", last_in_ready, c < 2);
         if (last_taken) idx++;
      end
      check_eq("bp_sent", idx, 5);
      drain();

      cyc_step(1'b0, '0, 1'b1, 1'b1);
      for (int k = 0; k < 5; k++) cyc_step(1'b1, 39'd1 << k, 1'b1, 1'b0);
      drain();
      check_eq("ce_sat", ce_cnt, 3);

      cyc_step(1'b0, '0, 1'b1, 1'b1);
      cyc_step(1'b1, 39'h00_0000_0001, 1'b1, 1'b0);
      cyc_step(1'b0, '0, 1'b1, 1'b1);
      drain();
      check_eq("clr_wins", ce_cnt, 0);

      for (int k = 0; k < 64; k++) begin
         d = $urandom;
         cw = {tb_enc(d), d};
         p1 = $urandom_range(0, 38);
         p2 = (p1 + $urandom_range(1, 38)) % 39;
         case ($urandom_range(0, 2))
            1: cw[p1] = ~cw[p1];
            2: begin cw[p1] = ~cw[p1]; cw[p2] = ~cw[p2]; end
            default: ;
         endcase
         rw[k] = cw;
      end
      idx = 0;
      for (int c = 0; c < 400 && idx < 64; c++) begin
         cyc_step(1'b1, rw[idx], $urandom_range(0, 3) != 0, 1'b0);
         if (last_taken) idx++;
      end
      check_eq("rand_sent", idx, 64);
      drain();

      cyc_step(1'b1, 39'h00_0000_0001, 1'b0, 1'b0);
      cyc_step(1'b1, 39'h00_0000_0003, 1'b0, 1'b0);
      cyc_step(1'b1, 39'h00_0000_0005, 1'b0, 1'b0);
      do_reset();
      for (int c = 0; c < 4; c++) cyc_step(1'b0, '0, 1'b1, 1'b0);
      check_eq("post_rst_ce_cnt", ce_cnt, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
